writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_pkg.sv | 14 +
 rtl/writeback_queue_if.sv | 35 +++
 rtl/wbq_fwd_match.sv | 36 +++
 rtl/writeback_queue.sv | 96 +++++++++
 tb/tb_writeback_queue.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_queue_pkg.sv
// Shared CPU definitions for the register writeback path: default widths
// and the {addr, data} write-entry layout.
package writeback_queue_pkg;

  localparam int CPU_DATA_W    = 20;
  localparam int CPU_ADDR_W    = 4;
  localparam int CPU_WBQ_DEPTH = 4;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer, register-bank and operand-forwarding signals of the writeback queue.
// The master side drives requests and acks; the slave side is the queue.
interface writeback_queue_if
  import writeback_queue_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = CPU_WBQ_DEPTH
) ();

  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic [ADDR_W-1:0]        in_addr;
  logic                     in_ready;
  logic                     flush;
  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic [ADDR_W-1:0]        wr_addr;
  logic                     wr_ack;
  logic [ADDR_W-1:0]        fwd_addr;
  logic                     fwd_hit;
  logic [DATA_W-1:0]        fwd_data;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_data, in_addr, flush, wr_ack, fwd_addr,
    input  in_ready, wr_en, wr_data, wr_addr, fwd_hit, fwd_data, count
  );

  modport slave (
    input  in_valid, in_data, in_addr, flush, wr_ack, fwd_addr,
    output in_ready, wr_en, wr_data, wr_addr, fwd_hit, fwd_data, count
  );

endinterface

// File: rtl/wbq_fwd_match.sv
// Operand forwarding: scans pending entries from newest to oldest and returns
// the data of the first one whose address matches.
module wbq_fwd_match #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] slot_addr_i [DEPTH],
  input  logic [DATA_W-1:0] slot_data_i [DEPTH],
  input  logic [PTR_W-1:0]  wr_ptr_i,
  input  logic [PTR_W:0]    count_i,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o
);

  logic [PTR_W-1:0] idx;

  // NOTE: every variable assigned in an always_comb gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    idx        = '0;
    // Slot wr_ptr-1 is the newest entry; only the first count slots are live.
    for (int k = 1; k <= DEPTH; k++) begin
      idx = wr_ptr_i - PTR_W'(k);
      if (!fwd_hit_o && (k <= int'(count_i)) && (slot_addr_i[idx] == fwd_addr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = slot_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Register writeback queue: a DEPTH-entry circular buffer of {addr, data}
// writes drained in order to the register bank, with newest-match forwarding.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = CPU_WBQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  writeback_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // A pop in the full cycle never frees room for a same-cycle push.
  assign in_ready = (count_q != CNT_W'(DEPTH)) && !bus.flush;
  assign push     = bus.in_valid && in_ready;
  assign wr_en    = (count_q != '0);
  assign pop      = wr_en && bus.wr_ack && !bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; every read of it is gated by count, so stale
  // contents are never visible and the array maps onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.in_addr;
      data_mem[wr_ptr_q] <= bus.in_data;
    end
  end

  wbq_fwd_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fwd_match (
    .slot_addr_i (addr_mem),
    .slot_data_i (data_mem),
    .wr_ptr_i    (wr_ptr_q),
    .count_i     (count_q),
    .fwd_addr_i  (bus.fwd_addr),
    .fwd_hit_o   (fwd_hit),
    .fwd_data_o  (fwd_data)
  );

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_en ? addr_mem[rd_ptr_q] : '0;
  assign bus.wr_data  = wr_en ? data_mem[rd_ptr_q] : '0;
  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_data;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a scoreboard queue holds every accepted
// write and is compared against the head entry as it drains.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  wb_entry_t sb[$];

  writeback_queue_if bus ();

  writeback_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int d, input logic ack, input logic fl);
    bus.in_valid = v;
    bus.in_addr  = CPU_ADDR_W'(a);
    bus.in_data  = CPU_DATA_W'(d);
    bus.wr_ack   = ack;
    bus.flush    = fl;
  endtask

  task automatic expect_push(input int a, input int d);
    wb_entry_t e;
    e.addr = CPU_ADDR_W'(a);
    e.data = CPU_DATA_W'(d);
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    wb_entry_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".wr_en"},   32'(bus.wr_en),   1);
      check({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(e.addr));
      check({tag, ".wr_data"}, 32'(bus.wr_data), 32'(e.data));
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.fwd_addr = '0;
    drive(0, 0, 0, 0, 0);

    // Reset state
    #12;
    check("rst.count",    32'(bus.count),    0);
    check("rst.in_ready", 32'(bus.in_ready), 1);
    check("rst.wr_en",    32'(bus.wr_en),    0);
    check("rst.wr_data",  32'(bus.wr_data),  0);
    check("rst.wr_addr",  32'(bus.wr_addr),  0);
    check("rst.fwd_hit",  32'(bus.fwd_hit),  0);
    check("rst.fwd_data", 32'(bus.fwd_data), 0);
    rst = 1'b0;

    // Single push with ack held high: visible one edge later, then gone
    drive(1, 5, 'h0ABCD, 1, 0);
    expect_push(5, 'h0ABCD);
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    pop_compare("single");
    tick();
    settle();
    check("single.count",   32'(bus.count),   0);
    check("single.wr_en",   32'(bus.wr_en),   0);
    check("single.wr_data", 32'(bus.wr_data), 0);
    check("single.wr_addr", 32'(bus.wr_addr), 0);

    // Fill to DEPTH, reject the fifth offer, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 'h100 + i, 0, 0);
      settle();
      check("fill.in_ready", 32'(bus.in_ready), 1);
      expect_push(i, 'h100 + i);
      tick();
    end
    drive(1, 9, 'h999, 0, 0);
    settle();
    check("full.count",    32'(bus.count),    4);
    check("full.in_ready", 32'(bus.in_ready), 0);
    tick();
    settle();
    check("full.reject_count", 32'(bus.count), 4);
    drive(1, 9, 'h999, 1, 0);
    settle();
    check("full_pop.in_ready", 32'(bus.in_ready), 0);
    pop_compare("drain0");
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    check("full_pop.count", 32'(bus.count), 3);
    for (int i = 0; i < 3; i++) begin
      pop_compare("drain");
      tick();
      settle();
    end
    check("drain.count", 32'(bus.count), 0);
    tick();
    settle();
    check("ack_empty.count", 32'(bus.count), 0);
    check("ack_empty.wr_en", 32'(bus.wr_en), 0);

    // Steady push+pop at count=2; pointers wrap several times
    drive(1, 'hA, 'h0AAAA, 0, 0);
    expect_push('hA, 'h0AAAA);
    tick();
    drive(1, 'hB, 'h0BBBB, 0, 0);
    expect_push('hB, 'h0BBBB);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, i, 'h2000 + i, 1, 0);
      settle();
      check("stream.count", 32'(bus.count), 2);
      expect_push(i, 'h2000 + i);
      pop_compare("stream");
      tick();
    end
    drive(0, 0, 0, 1, 0);
    settle();
    check("stream_end.count", 32'(bus.count), 2);
    pop_compare("stream_tail");
    tick();
    settle();
    pop_compare("stream_tail");
    tick();
    settle();
    check("stream_drained.count", 32'(bus.count), 0);

    // Forwarding: newest match wins, in-flight push is not visible
    drive(1, 3, 'h00011, 0, 0);
    expect_push(3, 'h00011);
    tick();
    drive(1, 3, 'h00022, 0, 0);
    expect_push(3, 'h00022);
    tick();
    drive(1, 8, 'h00044, 0, 0);
    bus.fwd_addr = 4'd8;
    settle();
    check("fwd_pushing.hit",  32'(bus.fwd_hit),  0);
    check("fwd_pushing.data", 32'(bus.fwd_data), 0);
    expect_push(8, 'h00044);
    tick();
    drive(0, 0, 0, 0, 0);
    bus.fwd_addr = 4'd3;
    settle();
    check("fwd_newest.hit",  32'(bus.fwd_hit),  1);
    check("fwd_newest.data", 32'(bus.fwd_data), 'h00022);
    bus.fwd_addr = 4'd7;
    settle();
    check("fwd_miss.hit",  32'(bus.fwd_hit),  0);
    check("fwd_miss.data", 32'(bus.fwd_data), 0);
    bus.fwd_addr = 4'd8;
    settle();
    check("fwd_tail.hit",  32'(bus.fwd_hit),  1);
    check("fwd_tail.data", 32'(bus.fwd_data), 'h00044);
    bus.fwd_addr = 4'd3;
    drive(0, 0, 0, 1, 0);
    settle();
    pop_compare("fwd_drain");
    tick();
    settle();
    check("fwd_popping.hit",  32'(bus.fwd_hit),  1);
    check("fwd_popping.data", 32'(bus.fwd_data), 'h00022);
    pop_compare("fwd_drain");
    tick();
    settle();
    check("fwd_popped.hit",  32'(bus.fwd_hit),  0);
    check("fwd_popped.data", 32'(bus.fwd_data), 0);
    pop_compare("fwd_drain");
    tick();
    settle();
    check("fwd_drained.count", 32'(bus.count), 0);

    // Flush at count=3 overrides the offered push and the ack
    for (int i = 1; i <= 3; i++) begin
      drive(1, i, 'h300 + i, 0, 0);
      expect_push(i, 'h300 + i);
      tick();
    end
    drive(1, 'hF, 'h0F0F, 1, 1);
    settle();
    check("flush.in_ready", 32'(bus.in_ready), 0);
    check("flush.count_pre", 32'(bus.count), 3);
    tick();
    drive(0, 0, 0, 0, 0);
    settle();
    sb.delete();
    check("flush.count",    32'(bus.count),    0);
    check("flush.wr_en",    32'(bus.wr_en),    0);
    check("flush.wr_data",  32'(bus.wr_data),  0);
    check("flush.in_ready", 32'(bus.in_ready), 1);
    drive(1, 'hC, 'h00055, 0, 0);
    expect_push('hC, 'h00055);
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    pop_compare("post_flush");
    tick();
    settle();
    check("post_flush.count", 32'(bus.count), 0);

    // Asynchronous reset between edges with two entries pending
    drive(1, 6, 'h00066, 0, 0);
    tick();
    drive(1, 7, 'h00077, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    bus.fwd_addr = 4'd7;
    settle();
    check("pre_rst.count",   32'(bus.count),   2);
    check("pre_rst.fwd_hit", 32'(bus.fwd_hit), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.count",    32'(bus.count),    0);
    check("async_rst.wr_en",    32'(bus.wr_en),    0);
    check("async_rst.wr_data",  32'(bus.wr_data),  0);
    check("async_rst.wr_addr",  32'(bus.wr_addr),  0);
    check("async_rst.in_ready", 32'(bus.in_ready), 1);
    check("async_rst.fwd_hit",  32'(bus.fwd_hit),  0);
    check("async_rst.fwd_data", 32'(bus.fwd_data), 0);
    sb.delete();
    #1;
    rst = 1'b0;
    drive(1, 'hD, 'h12345, 0, 0);
    bus.fwd_addr = 4'hD;
    expect_push('hD, 'h12345);
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    check("post_rst.fwd_hit",  32'(bus.fwd_hit),  1);
    check("post_rst.fwd_data", 32'(bus.fwd_data), 'h12345);
    pop_compare("post_rst");
    tick();
    settle();
    check("post_rst.count", 32'(bus.count), 0);
    check("post_rst.wr_en", 32'(bus.wr_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
